// File: rtl/v5_trap_filter_pkg.sv
// Shared widths, limits and the configuration record for the v5 trapezoidal filter.
// package_settings holds the system-wide sample widths; v5_parameters holds filter-specific values.
package package_settings;
  localparam int SIZE_ADC_DATA    = 14;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

package v5_parameters;
  import package_settings::*;

  localparam int MAX_K   = 16;
  localparam int MAX_L   = 32;
  localparam int M_W     = 12;
  localparam int ACC_W   = SIZE_ADC_DATA + 24;
  localparam int DEPTH   = MAX_K + MAX_L;
  localparam int K_W     = $clog2(MAX_K + 1);
  localparam int L_W     = $clog2(MAX_L + 1);
  localparam int SH_W    = 5;
  localparam int LATENCY = 6;

  typedef struct packed {
    logic [K_W-1:0]  k;
    logic [L_W-1:0]  l;
    logic [M_W-1:0]  m;
    logic [SH_W-1:0] shift;
  } filt_cfg_t;

  localparam filt_cfg_t CFG_RESET = '{k: K_W'(1), l: L_W'(1), m: '0, shift: '0};

  // A usable trapezoid needs a non-zero rise that fits inside the delay window.
  function automatic logic cfg_ok(input filt_cfg_t c);
    return (c.k >= K_W'(1)) && (c.k <= K_W'(MAX_K)) &&
           (c.l >= L_W'(c.k)) && (c.l <= L_W'(MAX_L));
  endfunction
endpackage

// File: rtl/v5_trap_filter_delay_line.sv
// Circular sample history with three programmable taps (K, L, K+L samples back).
// Taps read zero until enough samples have arrived since the last flush.
module v5_delay_line
  import package_settings::*, v5_parameters::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            wr_en,
  input  logic signed [SIZE_ADC_DATA-1:0] din,
  input  logic [K_W-1:0]                  k,
  input  logic [L_W-1:0]                  l,
  output logic signed [SIZE_ADC_DATA-1:0] tap_k,
  output logic signed [SIZE_ADC_DATA-1:0] tap_l,
  output logic signed [SIZE_ADC_DATA-1:0] tap_kl
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(DEPTH + 1);
  localparam int IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

  logic [PTR_W-1:0]                wr;
  logic [OFF_W-1:0]                fill;
  logic signed [SIZE_ADC_DATA-1:0] mem [DEPTH];
  logic [OFF_W-1:0]                off_k, off_l, off_kl;

  function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] w,
                                                input logic [OFF_W-1:0] off);
    logic [IDX_W-1:0] idx;
    idx = {1'b0, w} + DEPTH_I - IDX_W'(off);
    if (idx >= DEPTH_I) idx = idx - DEPTH_I;
    return PTR_W'(idx);
  endfunction

  // Reads happen before this cycle's write, so an offset of DEPTH still sees the oldest sample.
  always_comb begin
    off_k  = OFF_W'(k);
    off_l  = OFF_W'(l);
    off_kl = OFF_W'(k) + OFF_W'(l);
    tap_k  = (fill >= off_k)  ? mem[tap_addr(wr, off_k)]  : '0;
    tap_l  = (fill >= off_l)  ? mem[tap_addr(wr, off_l)]  : '0;
    tap_kl = (fill >= off_kl) ? mem[tap_addr(wr, off_kl)] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr   <= '0;
      fill <= '0;
    end else if (flush) begin
      wr   <= '0;
      fill <= '0;
    end else if (wr_en) begin
      wr <= (wr == PTR_W'(DEPTH - 1)) ? '0 : wr + PTR_W'(1);
      if (fill < OFF_W'(DEPTH)) fill <= fill + OFF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr] <= din;
  end
endmodule

// File: rtl/v5_trap_filter.sv
// Runtime-configurable trapezoidal shaper: delay-line taps, 6-stage arithmetic pipeline,
// saturating output with sticky overflow and a settled flag.
module v5_trap_filter
  import package_settings::*, v5_parameters::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic signed [SIZE_ADC_DATA-1:0]    input_data,
  input  logic                               cfg_we,
  input  logic [K_W-1:0]                     cfg_k,
  input  logic [L_W-1:0]                     cfg_l,
  input  logic [M_W-1:0]                     cfg_m,
  input  logic [SH_W-1:0]                    cfg_shift,
  output logic                               cfg_err,
  output logic                               out_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] output_data,
  output logic                               ovf,
  output logic                               settled
);
  localparam int X_W   = SIZE_ADC_DATA;
  localparam int Y_W   = SIZE_FILTER_DATA;
  localparam int D1_W  = X_W + 1;
  localparam int D_W   = X_W + 2;
  localparam int MD_W  = D_W + M_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};
  localparam logic signed [Y_W-1:0]   Y_MAX = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0]   Y_MIN = {1'b1, {(Y_W-1){1'b0}}};

  // Flow control is valid-only: a sample is taken when in_valid is high and cfg_we is low,
  // and reappears LATENCY edges later with out_valid high; there is no backpressure.
  filt_cfg_t cfg, cfg_in;
  logic      cfg_accept, flush, smp_en;
  logic [LATENCY-1:0] vld;

  logic signed [X_W-1:0]   x_r, xk_r, xl_r, xkl_r, tap_k, tap_l, tap_kl;
  logic signed [D1_W-1:0]  d1, d2;
  logic signed [D_W-1:0]   d;
  logic signed [MD_W-1:0]  md, md_d, md_m;
  logic signed [ACC_W-1:0] p, p1, r, s, s_sh, d_ext, md_ext;
  logic signed [Y_W-1:0]   y_sat;
  logic                    y_clamp;
  logic [CNT_W-1:0]        out_cnt, kl;

  assign cfg_in     = '{k: cfg_k, l: cfg_l, m: cfg_m, shift: cfg_shift};
  assign cfg_accept = cfg_ok(cfg_in);
  assign flush      = cfg_we && cfg_accept;
  assign smp_en     = in_valid && !cfg_we;

  v5_delay_line u_delay (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .wr_en  (smp_en),
    .din    (input_data),
    .k      (cfg.k),
    .l      (cfg.l),
    .tap_k  (tap_k),
    .tap_l  (tap_l),
    .tap_kl (tap_kl)
  );

  always_comb begin
    md_d    = {{(MD_W-D_W){d[D_W-1]}}, d};
    md_m    = {{(MD_W-M_W){1'b0}}, cfg.m};
    d_ext   = {{(ACC_W-D_W){d[D_W-1]}}, d};
    md_ext  = {{(ACC_W-MD_W){md[MD_W-1]}}, md};
    kl      = CNT_W'(cfg.k) + CNT_W'(cfg.l);
    s_sh    = s >>> cfg.shift;
    y_clamp = 1'b1;
    if (s_sh > S_MAX)      y_sat = Y_MAX;
    else if (s_sh < S_MIN) y_sat = Y_MIN;
    else begin
      y_sat   = Y_W'(s_sh);
      y_clamp = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg     <= CFG_RESET;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_accept;
      if (flush) cfg <= cfg_in;
    end
  end

  // Every stage register moves only with its own valid bit, so input gaps only stretch timing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0; x_r <= '0; xk_r <= '0; xl_r <= '0; xkl_r <= '0;
      d1 <= '0; d2 <= '0; d <= '0; p <= '0; p1 <= '0; md <= '0; r <= '0; s <= '0;
      out_valid <= 1'b0; output_data <= '0; ovf <= 1'b0; settled <= 1'b0; out_cnt <= '0;
    end else if (flush) begin
      vld <= '0; x_r <= '0; xk_r <= '0; xl_r <= '0; xkl_r <= '0;
      d1 <= '0; d2 <= '0; d <= '0; p <= '0; p1 <= '0; md <= '0; r <= '0; s <= '0;
      out_valid <= 1'b0; output_data <= '0; ovf <= 1'b0; settled <= 1'b0; out_cnt <= '0;
    end else begin
      vld       <= {vld[LATENCY-2:0], smp_en};
      out_valid <= vld[LATENCY-1];
      if (smp_en) begin
        x_r   <= input_data;
        xk_r  <= tap_k;
        xl_r  <= tap_l;
        xkl_r <= tap_kl;
      end
      if (vld[0]) begin
        d1 <= {x_r[X_W-1], x_r} - {xk_r[X_W-1], xk_r};
        d2 <= {xl_r[X_W-1], xl_r} - {xkl_r[X_W-1], xkl_r};
      end
      if (vld[1]) d <= {d1[D1_W-1], d1} - {d2[D1_W-1], d2};
      if (vld[2]) begin
        p  <= p + d_ext;
        p1 <= p;
        md <= md_d * md_m;
      end
      if (vld[3]) r <= p1 + md_ext;
      if (vld[4]) s <= s + r;
      if (vld[5]) begin
        output_data <= y_sat;
        if (y_clamp) ovf <= 1'b1;
        if (out_cnt < CNT_W'(DEPTH)) out_cnt <= out_cnt + CNT_W'(1);
        if (out_cnt + CNT_W'(1) >= kl) settled <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_v5_trap_filter.sv
// Bench for v5_trap_filter: randomized and directed stimulus against a per-sample
// arithmetic model of the trapezoid formulas, with an expected-output scoreboard.
module tb_v5_trap_filter;
  import package_settings::*, v5_parameters::*;

  localparam int XW = SIZE_ADC_DATA;
  localparam int YW = SIZE_FILTER_DATA;
  localparam int EW = YW + 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [XW-1:0] input_data = '0;
  logic                 cfg_we = 1'b0;
  logic [K_W-1:0]       cfg_k = '0;
  logic [L_W-1:0]       cfg_l = '0;
  logic [M_W-1:0]       cfg_m = '0;
  logic [SH_W-1:0]      cfg_shift = '0;
  logic                 cfg_err, out_valid, ovf, settled;
  logic signed [YW-1:0] output_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [EW-1:0]        exp_q[$];
  int                   lat_q[$];
  logic signed [YW-1:0] rec_q[$];
  logic signed [YW-1:0] step_seq[$];
  bit                   rec_en = 1'b0;
  logic signed [YW-1:0] last_y = '0;
  logic [EW-1:0]        mon_e;
  int                   mon_t;

  // Reference model state: samples since the last flush and running sums.
  int      mk = 1, ml = 1, mm = 0, msh = 0;
  longint  xs[$];
  longint  m_p = 0, m_s = 0;
  bit      m_ovf = 1'b0;

  v5_trap_filter dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .input_data  (input_data),
    .cfg_we      (cfg_we),
    .cfg_k       (cfg_k),
    .cfg_l       (cfg_l),
    .cfg_m       (cfg_m),
    .cfg_shift   (cfg_shift),
    .cfg_err     (cfg_err),
    .out_valid   (out_valid),
    .output_data (output_data),
    .ovf         (ovf),
    .settled     (settled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint wrap_acc(longint v);
    longint one, w;
    one = 1;
    w = v & ((one <<< ACC_W) - 1);
    if (w[ACC_W-1]) w = w - (one <<< ACC_W);
    return w;
  endfunction

  function automatic longint xv(int i);
    return (i >= 0) ? xs[i] : 0;
  endfunction

  task automatic model_reset(int k, int l, int m, int sh);
    mk = k; ml = l; mm = m; msh = sh;
    xs.delete();
    m_p = 0; m_s = 0; m_ovf = 1'b0;
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic model_push(longint x);
    longint d, rr, sh, ymax, ymin;
    logic signed [YW-1:0] y;
    int n;
    bit sett;
    ymax = (longint'(1) <<< (YW - 1)) - 1;
    ymin = -ymax - 1;
    xs.push_back(x);
    n  = xs.size() - 1;
    d  = xv(n) - xv(n - mk) - xv(n - ml) + xv(n - mk - ml);
    rr = wrap_acc(m_p + longint'(mm) * d);
    m_p = wrap_acc(m_p + d);
    m_s = wrap_acc(m_s + rr);
    sh = m_s >>> msh;
    if (sh > ymax) begin
      y = YW'(ymax); m_ovf = 1'b1;
    end else if (sh < ymin) begin
      y = YW'(ymin); m_ovf = 1'b1;
    end else begin
      y = YW'(sh);
    end
    sett = (n + 1) >= (mk + ml);
    exp_q.push_back({m_ovf, sett, y});
  endtask

  task automatic drive(bit v, longint x);
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = v;
    input_data = XW'(x);
    if (v) begin
      model_push(x);
      lat_q.push_back(cyc + 1);
    end
  endtask

  function automatic longint rand_x();
    return longint'($urandom_range(0, 16382)) - 8191;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (lat_q.size() != 0 && n < 40) begin
      drive(1'b0, rand_x());
      n++;
    end
    checks++;
    if (lat_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", lat_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic do_cfg(int k, int l, int m, int sh);
    bit ok;
    ok = (k >= 1) && (k <= MAX_K) && (l >= k) && (l <= MAX_L);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_k = K_W'(k); cfg_l = L_W'(l); cfg_m = M_W'(m); cfg_shift = SH_W'(sh);
    in_valid = 1'($urandom_range(0, 1));
    input_data = XW'(rand_x());
    if (ok) model_reset(k, l, m, sh);
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== !ok) begin
      errors++;
      $display("FAIL cfg_err k=%0d l=%0d got=%b want=%b", k, l, cfg_err, !ok);
    end
    if (ok) begin
      checks++;
      if ({out_valid, settled, ovf} !== 3'b000) begin
        errors++;
        $display("FAIL flush_flags got out_valid/settled/ovf=%b%b%b want=000", out_valid, settled, ovf);
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse got=%b want=0", cfg_err);
    end
  endtask

  task automatic send_step(int zeros, int steps, longint amp, int gap);
    for (int i = 0; i < zeros + steps; i++) begin
      drive(1'b1, (i < zeros) ? 0 : amp);
      for (int g = 0; g < gap; g++) drive(1'b0, rand_x());
    end
  endtask

  task automatic check_final(string name, logic signed [YW-1:0] want_y, logic want_ovf);
    checks++;
    if (last_y !== want_y || ovf !== want_ovf || settled !== 1'b1) begin
      errors++;
      $display("FAIL %s got y=%0d ovf=%b settled=%b want y=%0d ovf=%b settled=1",
               name, last_y, ovf, settled, want_y, want_ovf);
    end
  endtask

  // Scoreboard: every out_valid must match the oldest expected output and its latency.
  always @(posedge clk) begin
    #1;
    if (reset && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cyc=%0d data=%0d want no output", cyc, output_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = lat_q.pop_front();
        if ({ovf, settled, output_data} !== mon_e || cyc != mon_t + LATENCY) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d got ovf=%b settled=%b y=%0d want ovf=%b settled=%b y=%0d at cyc %0d",
                   cyc, ovf, settled, output_data, mon_e[EW-1], mon_e[EW-2],
                   $signed(mon_e[YW-1:0]), mon_t + LATENCY);
        end
      end
      last_y = output_data;
      if (rec_en) rec_q.push_back(output_data);
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      input_data = XW'(rand_x());
      cfg_we = 1'($urandom_range(0, 1));
      cfg_k = K_W'($urandom_range(0, 31));
      cfg_l = L_W'($urandom_range(0, 63));
      #2;
      checks++;
      if ({cfg_err, out_valid, ovf, settled, output_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got err=%b ov=%b ovf=%b set=%b y=%0d want all 0",
                 cfg_err, out_valid, ovf, settled, output_data);
      end
    end
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0; reset = 1'b1;
    model_reset(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 0);
    drain();
    check_final("reset_zero_input", 0, 1'b0);
  endtask

  task automatic test_step();
    do_cfg(2, 4, 0, 0);
    rec_q.delete();
    rec_en = 1'b1;
    send_step(8, 24, 100, 0);
    drain();
    rec_en = 1'b0;
    step_seq = rec_q;
    check_final("step_800", 800, 1'b0);
    do_cfg(2, 4, 0, 3);
    send_step(8, 24, 100, 0);
    drain();
    check_final("step_shift3_100", 100, 1'b0);
  endtask

  task automatic test_gapped();
    do_cfg(2, 4, 0, 0);
    rec_q.delete();
    rec_en = 1'b1;
    send_step(8, 24, 100, 2);
    drain();
    rec_en = 1'b0;
    checks++;
    if (rec_q.size() != step_seq.size()) begin
      errors++;
      $display("FAIL gapped_count got=%0d want=%0d", rec_q.size(), step_seq.size());
    end
    for (int i = 0; i < rec_q.size() && i < step_seq.size(); i++) begin
      checks++;
      if (rec_q[i] !== step_seq[i]) begin
        errors++;
        $display("FAIL gapped_seq idx=%0d got=%0d want=%0d", i, rec_q[i], step_seq[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_cfg(8, 16, 0, 0);
    send_step(4, 40, 8000, 0);
    drain();
    check_final("sat_pos", 32767, 1'b1);
    do_cfg(8, 16, 0, 0);
    send_step(4, 40, -8000, 0);
    drain();
    check_final("sat_neg", -32768, 1'b1);
  endtask

  task automatic test_bad_config();
    do_cfg(3, 6, 5, 2);
    for (int i = 0; i < 10; i++) drive(1'b1, rand_x());
    do_cfg(5, 3, 7, 1);
    for (int i = 0; i < 10; i++) drive(1'b1, rand_x());
    do_cfg(0, 4, 1, 1);
    do_cfg(17, 20, 1, 1);
    do_cfg(4, 33, 1, 1);
    for (int i = 0; i < 12; i++) drive(1'b1, rand_x());
    drain();
    for (int i = 0; i < 5; i++) drive(1'b1, rand_x());
    do_cfg(4, 8, 3, 1);
    for (int i = 0; i < 20; i++) drive(1'b1, rand_x());
    drain();
  endtask

  task automatic test_random();
    int k, l;
    for (int round = 0; round < 5; round++) begin
      k = $urandom_range(1, MAX_K);
      l = $urandom_range(k, MAX_L);
      do_cfg(k, l, $urandom_range(0, 4095), $urandom_range(0, 31));
      for (int i = 0; i < 70; i++) drive(1'($urandom_range(0, 2) != 0), rand_x());
      drain();
    end
  endtask

  task automatic test_async_reset();
    do_cfg(2, 4, 0, 0);
    send_step(4, 10, 100, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cfg_err, out_valid, ovf, settled, output_data} !== '0) begin
      errors++;
      $display("FAIL async_reset got ov=%b ovf=%b set=%b y=%0d want all 0",
               out_valid, ovf, settled, output_data);
    end
    model_reset(1, 1, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_cfg(2, 4, 0, 0);
    send_step(8, 24, 100, 0);
    drain();
    check_final("restart_step_800", 800, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step();
    test_gapped();
    test_saturation();
    test_bad_config();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
